// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one SRAM-like bus port.
// One transaction outstanding at a time; requester fields latched at grant.
module mem_arbiter #(
    parameter int DATA_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t      r_state;
    state_t      w_next;
    owner_t      r_owner;
    logic        r_last_d;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic w_idle;
    logic w_pick_d;
    logic w_grant_d;
    logic w_grant_i;
    logic w_done;

    // Data side wins a tie if fixed priority, or if fetch owned the bus last.
    assign w_idle    = (r_state == IDLE) && !rst;
    assign w_pick_d  = d_req && (!i_req || (DATA_PRIORITY != 0) || !r_last_d);
    assign w_grant_d = w_idle && w_pick_d;
    assign w_grant_i = w_idle && i_req && !w_pick_d;

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_d || w_grant_i)
                    w_next = ADDR;
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        w_done = !rst;
                        w_next = IDLE;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    w_done = !rst;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_NONE;
            r_last_d <= 1'b0;
            r_wr     <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_grant_d) begin
                r_owner  <= OWN_D;
                r_last_d <= 1'b1;
                r_wr     <= d_wr;
                r_size   <= d_size;
                r_addr   <= d_addr;
                r_wdata  <= d_wdata;
                r_wstrb  <= d_wstrb;
            end else if (w_grant_i) begin
                r_owner  <= OWN_I;
                r_last_d <= 1'b0;
                r_wr     <= i_wr;
                r_size   <= i_size;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end else if (w_done) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign i_addr_ok = w_grant_i;
    assign d_addr_ok = w_grant_d;
    assign i_data_ok = w_done && (r_owner == OWN_I);
    assign d_data_ok = w_done && (r_owner == OWN_D);
    assign i_rdata   = bus_rdata;
    assign d_rdata   = bus_rdata;

    assign bus_req   = (r_state == ADDR) && !rst;
    assign bus_wr    = r_wr;
    assign bus_size  = r_size;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_wstrb = r_wstrb;
    assign busy      = (r_state != IDLE) && !rst;

endmodule
